imem_port_arbiter: RTL and testbench

Sequences and shares the single-port instruction memory behind the fetch stage among three requesters: the PC-driven fetch path, the external controller (program load writes and debug reads), and the memory BIST engine. Fixed-priority arbitration with an optional fetch starvation guard. BIST is granted exclusive ownership only after any in-flight read has drained. Sits between the fetch PC logic, the controller interface and the instruction SRAM macro, which has a 1-cycle synchronous read.

---
 rtl/imem_arb_pkg.sv | 17 +
 rtl/imem_arb_starve_cnt.sv | 30 +++
 rtl/imem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_imem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// Shared encodings for the instruction-memory port arbiter.
// FSM states and the read-return source tag.
package imem_arb_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        DRAIN = 2'd1,
        BIST  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_FETCH = 2'd1,
        SRC_CNTLR = 2'd2
    } src_tag_t;

endpackage

// File: rtl/imem_arb_starve_cnt.sv
// Saturating count of consecutive denied fetch cycles.
// promote is high while the count sits at MAX.
module imem_arb_starve_cnt
    import imem_arb_pkg::*;
#(
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic promote
);

    localparam int W = $clog2(MAX + 1);
    localparam logic [W-1:0] CMAX = W'(MAX);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && cnt != CMAX) begin
            cnt <= cnt + W'(1);
        end
    end

    assign promote = (cnt == CMAX);

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction SRAM among fetch, controller and BIST.
// Optional fetch starvation guard: define IMEM_ARB_STARVE_GUARD_EN.
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bist_en,
    output logic                  bist_own,
    input  logic                  bist_we,
    input  logic [ADDR_WIDTH-1:0] bist_addr,
    input  logic [DATA_WIDTH-1:0] bist_wdata,
    output logic [DATA_WIDTH-1:0] bist_rdata,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_gnt,
    output logic                  fetch_rvalid,
    output logic [DATA_WIDTH-1:0] fetch_rdata,
    input  logic                  cntlr_wr,
    input  logic [ADDR_WIDTH-1:0] cntlr_waddr,
    input  logic [DATA_WIDTH-1:0] cntlr_wr_data,
    output logic                  cntlr_wr_gnt,
    input  logic                  cntlr_rd,
    input  logic [ADDR_WIDTH-1:0] cntlr_raddr,
    output logic                  cntlr_rd_gnt,
    output logic                  cntlr_rd_valid,
    output logic [DATA_WIDTH-1:0] cntlr_rd_data,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    arb_state_t state;
    src_tag_t   tag_q;
    logic       bist_own_q;
    logic       arb_ok;
    logic       bist_act;
    logic       fetch_hi;
    logic       wr_gnt;
    logic       rd_gnt;
    logic       f_gnt;

    assign arb_ok   = !rst && state == ARB && !bist_en;
    assign bist_act = !rst && bist_own_q;

`ifdef IMEM_ARB_STARVE_GUARD_EN
    logic promote;

    imem_arb_starve_cnt #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .inc     (fetch_req && !f_gnt),
        .clr     (!fetch_req || f_gnt || state != ARB),
        .promote (promote)
    );

    assign fetch_hi = promote && fetch_req;
`else
    logic unused_starve;
    assign unused_starve = (STARVE_MAX == 0);
    assign fetch_hi      = 1'b0;
`endif

    assign wr_gnt = arb_ok && cntlr_wr && !fetch_hi;
    assign rd_gnt = arb_ok && cntlr_rd && !cntlr_wr && !fetch_hi;
    assign f_gnt  = arb_ok && fetch_req
                  && (fetch_hi || (!cntlr_wr && !cntlr_rd));

    assign cntlr_wr_gnt = wr_gnt;
    assign cntlr_rd_gnt = rd_gnt;
    assign fetch_gnt    = f_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            bist_own_q <= 1'b0;
            tag_q      <= SRC_NONE;
        end else begin
            unique case (state)
                ARB: begin
                    if (bist_en) state <= DRAIN;
                end
                DRAIN: begin
                    state      <= BIST;
                    bist_own_q <= 1'b1;
                end
                BIST: begin
                    if (!bist_en) begin
                        state      <= ARB;
                        bist_own_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= ARB;
                    bist_own_q <= 1'b0;
                end
            endcase
            tag_q <= f_gnt  ? SRC_FETCH :
                     rd_gnt ? SRC_CNTLR : SRC_NONE;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (1'b1)
            bist_act: begin
                mem_en    = 1'b1;
                mem_we    = bist_we;
                mem_addr  = bist_addr;
                mem_wdata = bist_wdata;
            end
            wr_gnt: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cntlr_waddr;
                mem_wdata = cntlr_wr_data;
            end
            rd_gnt: begin
                mem_en   = 1'b1;
                mem_addr = cntlr_raddr;
            end
            f_gnt: begin
                mem_en   = 1'b1;
                mem_addr = fetch_addr;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    // A return tag left over when rst lands is dropped, not replayed.
    assign fetch_rvalid   = !rst && tag_q == SRC_FETCH;
    assign cntlr_rd_valid = !rst && tag_q == SRC_CNTLR;
    assign fetch_rdata    = fetch_rvalid ? mem_rdata : '0;
    assign cntlr_rd_data  = cntlr_rd_valid ? mem_rdata : '0;
    assign bist_rdata     = mem_rdata;
    assign bist_own       = bist_own_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural 1-cycle SRAM.
// Unwritten words read back as 32'h1000_0000 | address.
module tb_imem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        bist_en;
    logic        bist_own;
    logic        bist_we;
    logic [10:0] bist_addr;
    logic [31:0] bist_wdata;
    logic [31:0] bist_rdata;
    logic        fetch_req;
    logic [10:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_rvalid;
    logic [31:0] fetch_rdata;
    logic        cntlr_wr;
    logic [10:0] cntlr_waddr;
    logic [31:0] cntlr_wr_data;
    logic        cntlr_wr_gnt;
    logic        cntlr_rd;
    logic [10:0] cntlr_raddr;
    logic        cntlr_rd_gnt;
    logic        cntlr_rd_valid;
    logic [31:0] cntlr_rd_data;
    logic        mem_en;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:2047];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    imem_port_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .bist_en        (bist_en),
        .bist_own       (bist_own),
        .bist_we        (bist_we),
        .bist_addr      (bist_addr),
        .bist_wdata     (bist_wdata),
        .bist_rdata     (bist_rdata),
        .fetch_req      (fetch_req),
        .fetch_addr     (fetch_addr),
        .fetch_gnt      (fetch_gnt),
        .fetch_rvalid   (fetch_rvalid),
        .fetch_rdata    (fetch_rdata),
        .cntlr_wr       (cntlr_wr),
        .cntlr_waddr    (cntlr_waddr),
        .cntlr_wr_data  (cntlr_wr_data),
        .cntlr_wr_gnt   (cntlr_wr_gnt),
        .cntlr_rd       (cntlr_rd),
        .cntlr_raddr    (cntlr_raddr),
        .cntlr_rd_gnt   (cntlr_rd_gnt),
        .cntlr_rd_valid (cntlr_rd_valid),
        .cntlr_rd_data  (cntlr_rd_data),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 32'h1000_0000 | i;
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bist_en = 1'b0; bist_we = 1'b0; bist_addr = '0; bist_wdata = '0;
        fetch_req = 1'b1; fetch_addr = 11'd0;
        cntlr_wr = 1'b1; cntlr_waddr = 11'd5; cntlr_wr_data = 32'hA5A5_0001;
        cntlr_rd = 1'b1; cntlr_raddr = 11'd5;

        // reset with every request high
        @(negedge clk);
        chk("rst_wr_gnt", 32'(cntlr_wr_gnt), 32'd0);
        chk("rst_rd_gnt", 32'(cntlr_rd_gnt), 32'd0);
        chk("rst_f_gnt", 32'(fetch_gnt), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_bist_own", 32'(bist_own), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rst_f_rvalid", 32'(fetch_rvalid), 32'd0);
        chk("rst_c_rvalid", 32'(cntlr_rd_valid), 32'd0);
        next_cycle();

        // release: write beats read and fetch
        rst = 1'b0;
        @(negedge clk);
        chk("wr_gnt", 32'(cntlr_wr_gnt), 32'd1);
        chk("wr_rd_gnt", 32'(cntlr_rd_gnt), 32'd0);
        chk("wr_f_gnt", 32'(fetch_gnt), 32'd0);
        chk("wr_mem_we", 32'(mem_we), 32'd1);
        chk("wr_mem_addr", 32'(mem_addr), 32'd5);
        chk("wr_mem_wdata", mem_wdata, 32'hA5A5_0001);
        next_cycle();
        cntlr_wr = 1'b0;
        @(negedge clk);
        chk("rd_gnt", 32'(cntlr_rd_gnt), 32'd1);
        chk("rd_f_gnt", 32'(fetch_gnt), 32'd0);
        next_cycle();
        cntlr_rd = 1'b0; fetch_req = 1'b0;
        @(negedge clk);
        chk("rd_valid", 32'(cntlr_rd_valid), 32'd1);
        chk("rd_data", cntlr_rd_data, 32'hA5A5_0001);
        chk("rd_f_rvalid", 32'(fetch_rvalid), 32'd0);
        chk("idle_mem_en", 32'(mem_en), 32'd0);
        next_cycle();

        // back-to-back fetch of 0..4
        fetch_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            fetch_addr = 11'(k);
            @(negedge clk);
            chk($sformatf("f_gnt_%0d", k), 32'(fetch_gnt), 32'd1);
            chk($sformatf("f_rv_%0d", k), 32'(fetch_rvalid),
                (k == 0) ? 32'd0 : 32'd1);
            if (k > 0)
                chk($sformatf("f_rd_%0d", k), fetch_rdata,
                    32'h1000_0000 + 32'(k - 1));
            next_cycle();
        end
        fetch_addr = 11'd5; cntlr_rd = 1'b1; cntlr_raddr = 11'd7;
        @(negedge clk);
        chk("int_f_gnt", 32'(fetch_gnt), 32'd0);
        chk("int_rd_gnt", 32'(cntlr_rd_gnt), 32'd1);
        chk("int_f_rd4", fetch_rdata, 32'h1000_0004);
        next_cycle();
        cntlr_rd = 1'b0;
        @(negedge clk);
        chk("int_f_gnt2", 32'(fetch_gnt), 32'd1);
        chk("int_c_valid", 32'(cntlr_rd_valid), 32'd1);
        chk("int_c_data", cntlr_rd_data, 32'h1000_0007);
        chk("int_f_rvalid", 32'(fetch_rvalid), 32'd0);
        next_cycle();
        fetch_req = 1'b0;
        @(negedge clk);
        chk("f5_rvalid", 32'(fetch_rvalid), 32'd1);
        chk("f5_data", fetch_rdata, 32'hA5A5_0001);
        next_cycle();

        // controller read held against fetch
        cntlr_rd = 1'b1; cntlr_raddr = 11'd1;
        fetch_req = 1'b1; fetch_addr = 11'd2;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
`ifdef IMEM_ARB_STARVE_GUARD_EN
            chk($sformatf("stv_f_%0d", i), 32'(fetch_gnt),
                (i == 9) ? 32'd1 : 32'd0);
            chk($sformatf("stv_c_%0d", i), 32'(cntlr_rd_gnt),
                (i == 9) ? 32'd0 : 32'd1);
`else
            chk($sformatf("stv_f_%0d", i), 32'(fetch_gnt), 32'd0);
            chk($sformatf("stv_c_%0d", i), 32'(cntlr_rd_gnt), 32'd1);
`endif
            next_cycle();
        end
        cntlr_rd = 1'b0; fetch_req = 1'b0;
        next_cycle();

        // fetch in flight, then BIST takes the port
        fetch_req = 1'b1; fetch_addr = 11'd3;
        @(negedge clk);
        chk("b_f_gnt", 32'(fetch_gnt), 32'd1);
        next_cycle();
        bist_en = 1'b1;
        @(negedge clk);
        chk("b_req_f_gnt", 32'(fetch_gnt), 32'd0);
        chk("b_req_rvalid", 32'(fetch_rvalid), 32'd1);
        chk("b_req_rdata", fetch_rdata, 32'h1000_0003);
        chk("b_req_own", 32'(bist_own), 32'd0);
        next_cycle();
        bist_addr = 11'd7;
        @(negedge clk);
        chk("drain_own", 32'(bist_own), 32'd0);
        chk("drain_mem_en", 32'(mem_en), 32'd0);
        chk("drain_rvalid", 32'(fetch_rvalid), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("bist_own", 32'(bist_own), 32'd1);
        chk("bist_mem_en", 32'(mem_en), 32'd1);
        chk("bist_mem_addr", 32'(mem_addr), 32'd7);
        chk("bist_f_gnt", 32'(fetch_gnt), 32'd0);
        next_cycle();
        bist_en = 1'b0;
        @(negedge clk);
        chk("bist_rdata", bist_rdata, 32'h1000_0007);
        chk("bist_own_hold", 32'(bist_own), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("post_bist_own", 32'(bist_own), 32'd0);
        chk("post_bist_gnt", 32'(fetch_gnt), 32'd1);
        next_cycle();
        fetch_req = 1'b0;
        next_cycle();

        // reset lands while a controller read is outstanding
        cntlr_rd = 1'b1; cntlr_raddr = 11'd7;
        @(negedge clk);
        chk("rr_gnt", 32'(cntlr_rd_gnt), 32'd1);
        next_cycle();
        cntlr_rd = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rr_valid_rst", 32'(cntlr_rd_valid), 32'd0);
        chk("rr_mem_en_rst", 32'(mem_en), 32'd0);
        next_cycle();
        rst = 1'b0; fetch_req = 1'b1; fetch_addr = 11'd0;
        @(negedge clk);
        chk("rr_valid_after", 32'(cntlr_rd_valid), 32'd0);
        chk("rr_arb_gnt", 32'(fetch_gnt), 32'd1);
        chk("rr_own", 32'(bist_own), 32'd0);
        next_cycle();
        fetch_req = 1'b0;
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
